// File: rtl/alu_result_buffer_pkg.sv
// Shared definitions for the ALU result buffer: op encodings, flag bit
// positions, buffer occupancy states and small helpers.
package alu_result_buffer_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_INC  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] OVF_COUNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'b00,
        BUF_PARTIAL = 2'b01,
        BUF_FULL    = 2'b10
    } buf_state_e;

    function automatic buf_state_e occupancy_state(input int occ, input int depth);
        buf_state_e st;
        if (occ == 0) begin
            st = BUF_EMPTY;
        end else if (occ >= depth) begin
            st = BUF_FULL;
        end else begin
            st = BUF_PARTIAL;
        end
        return st;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == OVF_COUNT_MAX) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/alu_result_buffer_flag_gen.sv
// Combinational {N,Z,C,V} derivation from the arithmetic stage outputs;
// subtract reports carry as borrow, increment and pass never overflow.
module alu_flag_gen
    import alu_result_buffer_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]  res,
    input  logic              cout,
    input  logic              neg,
    input  logic              ovf,
    input  logic [1:0]        op,
    output logic [FLAG_W-1:0] flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = neg;
        flags[FLAG_Z] = (res == '0);
        case (op_e'(op))
            OP_ADD: begin
                flags[FLAG_C] = cout;
                flags[FLAG_V] = ovf;
            end
            OP_SUB: begin
                flags[FLAG_C] = ~cout;
                flags[FLAG_V] = ovf;
            end
            OP_INC: begin
                flags[FLAG_C] = cout;
            end
            OP_PASS: begin
                flags[FLAG_C] = 1'b0;
            end
            default: begin
                flags[FLAG_C] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results with flags captured at accept time, plus a sticky
// overflow indicator and a saturating overflow counter.
//
// state       | meaning
// ------------|---------------------------------------------
// BUF_EMPTY   | no entries; out_valid=0, outputs hold last pop
// BUF_PARTIAL | 1..DEPTH-1 entries; push and pop both allowed
// BUF_FULL    | DEPTH entries; in_ready=0, no pass-through
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  res_in,
    input  logic              cout_in,
    input  logic              neg_in,
    input  logic              ovf_in,
    input  logic [1:0]        op_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  res_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic              sticky_ovf,
    output logic [3:0]        ovf_count,
    input  logic              clr_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    buf_state_e        state_q;
    buf_state_e        state_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;

    logic [WIDTH-1:0]  mem_res   [DEPTH];
    logic [FLAG_W-1:0] mem_flags [DEPTH];
    logic [WIDTH-1:0]  last_res_q;
    logic [FLAG_W-1:0] last_flags_q;

    logic [FLAG_W-1:0] flags_new;
    logic              push;
    logic              pop;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .res   (res_in),
        .cout  (cout_in),
        .neg   (neg_in),
        .ovf   (ovf_in),
        .op    (op_in),
        .flags (flags_new)
    );

    // Handshakes look only at registered state, so a full buffer never
    // accepts in the same cycle it pops.
    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign push      = in_valid & in_ready & ~rst;
    assign pop       = out_valid & out_ready & ~rst;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        state_d = occupancy_state(int'(count_d), DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BUF_EMPTY;
            count_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            last_res_q   <= '0;
            last_flags_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q       <= rptr_q + PW'(1);
                last_res_q   <= mem_res[rptr_q];
                last_flags_q <= mem_flags[rptr_q];
            end
        end
    end

    // Entry storage is never read while its slot is empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wptr_q]   <= res_in;
            mem_flags[wptr_q] <= flags_new;
        end
    end

    assign res_out   = out_valid ? mem_res[rptr_q]   : last_res_q;
    assign flags_out = out_valid ? mem_flags[rptr_q] : last_flags_q;

    // Clear takes priority over a same-cycle overflowing accept.
    always_ff @(posedge clk) begin
        if (rst || clr_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (push && flags_new[FLAG_V]) begin
            sticky_ovf <= 1'b1;
            ovf_count  <= sat_inc(ovf_count);
        end
    end

endmodule
